// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the state encoding, the NOOP opcode and the instruction-word width helper.
package seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_I,
      ST_EXEC,
      ST_MEM,
      ST_HALT
   } seq_state_e;

   localparam int OPC_WIDTH = 6;
   localparam int CNT_WIDTH = 3;
   localparam logic [OPC_WIDTH-1:0] OPC_NOOP = 6'b000001;

   function automatic int instrWidth(input int immWidth);
      return OPC_WIDTH + immWidth;
   endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Loadable 3-bit down-counter used for both instruction-fetch latency and data-memory wait states.
module seq_wait_counter
   import seq_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [CNT_WIDTH-1:0] loadVal_i,
   input  logic                 dec_i,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic                 zero_o
);

   logic [CNT_WIDTH-1:0] count_q, count_d;

   // Load takes priority over decrement; the count saturates at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = loadVal_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute controller: drives PC and instruction-RAM reads, holds the IR,
// and turns decoder flags into the execute strobe, PC updates and data-memory write wait states.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int PC_WIDTH     = 8,
   parameter int IMM_WIDTH    = 8,
   parameter int IRAM_LATENCY = 1,
   parameter int DRAM_WAIT    = 2
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [instrWidth(IMM_WIDTH)-1:0]     iram_data,
   input  logic                                 pc_en,
   input  logic                                 stop_flag,
   input  logic                                 data_write_en,
   input  logic                                 jump_load,
   input  logic [PC_WIDTH-1:0]                  jump_target,
   output logic [PC_WIDTH-1:0]                  pc,
   output logic                                 iram_rd_en,
   output logic [OPC_WIDTH-1:0]                 opcode,
   output logic [IMM_WIDTH-1:0]                 imm,
   output logic                                 exec_en,
   output logic                                 data_we,
   output logic                                 busy,
   output logic                                 done
);

   localparam int IW = instrWidth(IMM_WIDTH);

   seq_state_e            state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [OPC_WIDTH-1:0]  opcode_q, opcode_d;
   logic [IMM_WIDTH-1:0]  imm_q, imm_d;

   logic                  cntLoad;
   logic                  cntDec;
   logic [CNT_WIDTH-1:0]  cntLoadVal;
   logic [CNT_WIDTH-1:0]  cntValue;
   logic                  cntZero;
   logic                  cntLast;

   seq_wait_counter uWaitCounter (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (cntLoad),
      .loadVal_i (cntLoadVal),
      .dec_i     (cntDec),
      .count_o   (cntValue),
      .zero_o    (cntZero)
   );

   // A zero count also ends a wait, so a misloaded counter can never stall the sequencer.
   assign cntLast = (cntValue == CNT_WIDTH'(1)) || cntZero;

   // Next-state, PC/IR update and strobe generation.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      opcode_d   = opcode_q;
      imm_d      = imm_q;
      cntLoad    = 1'b0;
      cntDec     = 1'b0;
      cntLoadVal = '0;
      iram_rd_en = 1'b0;
      exec_en    = 1'b0;
      data_we    = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end

         ST_FETCH: begin
            iram_rd_en = 1'b1;
            cntLoad    = 1'b1;
            cntLoadVal = CNT_WIDTH'(IRAM_LATENCY);
            state_d    = ST_WAIT_I;
         end

         ST_WAIT_I: begin
            cntDec = 1'b1;
            if (cntLast) begin
               opcode_d = iram_data[IW-1 -: OPC_WIDTH];
               imm_d    = iram_data[IMM_WIDTH-1:0];
               state_d  = ST_EXEC;
            end
         end

         // Halt beats write, write beats jump, jump beats sequential advance.
         ST_EXEC: begin
            exec_en = 1'b1;
            if (stop_flag) begin
               state_d = ST_HALT;
            end else if (data_write_en) begin
               cntLoad    = 1'b1;
               cntLoadVal = CNT_WIDTH'(DRAM_WAIT);
               state_d    = ST_MEM;
            end else begin
               if (jump_load) begin
                  pc_d = jump_target;
               end else if (pc_en) begin
                  pc_d = pc_q + PC_WIDTH'(1);
               end
               state_d = ST_FETCH;
            end
         end

         ST_MEM: begin
            data_we = 1'b1;
            cntDec  = 1'b1;
            if (cntLast) begin
               pc_d    = pc_q + PC_WIDTH'(1);
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         opcode_q <= OPC_NOOP;
         imm_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         imm_q    <= imm_d;
      end
   end

   assign pc     = pc_q;
   assign opcode = opcode_q;
   assign imm    = imm_q;
   assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
   assign done   = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a default build (A) and an IRAM_LATENCY=3 build (B),
// each fed by a behavioural instruction RAM and a toy decoder.
module tb_instr_sequencer;

   localparam int PCW = 8;
   localparam int IMMW = 8;
   localparam int DW = 2;
   localparam logic [5:0] OP_NOOP    = 6'h01;
   localparam logic [5:0] OP_LDP1    = 6'h02;
   localparam logic [5:0] OP_STR     = 6'h03;
   localparam logic [5:0] OP_JUMPX   = 6'h04;
   localparam logic [5:0] OP_STRSTOP = 6'h05;
   localparam logic [5:0] OP_STOP    = 6'h3F;
   localparam logic [13:0] JUNK      = 14'h2AA5;

   typedef struct {
      logic [7:0] pc;
      logic [5:0] op;
      logic [7:0] imm;
      int         gap;
   } execRec_t;

   logic clk = 1'b0;
   logic rst;
   logic startA, startB;

   logic [13:0] iramDataA, iramDataB;
   logic pcEnA, stopA, dweA, jlA, pcEnB, stopB, dweB, jlB;
   logic [7:0] jtA, jtB, pcA, pcB, immA, immB;
   logic [5:0] opA, opB;
   logic iramRdEnA, execEnA, dataWeA, busyA, doneA;
   logic iramRdEnB, execEnB, dataWeB, busyB, doneB;

   logic [13:0] memA [256];
   logic [13:0] memB [256];

   execRec_t   execQ[$];
   logic [7:0] fetchQ[$];
   execRec_t   rec;
   logic [7:0] expAddr;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int lastExecA = 0;
   int strExecA = -10;
   int weRunA = 0;
   int weRuns = 0;
   logic weLastA = 1'b0;
   int fetchCntB = 0;

   always #5 clk = ~clk;

   instr_sequencer #(.PC_WIDTH(PCW), .IMM_WIDTH(IMMW), .IRAM_LATENCY(1), .DRAM_WAIT(DW)) dutA (
      .clk(clk), .rst(rst), .start(startA), .iram_data(iramDataA),
      .pc_en(pcEnA), .stop_flag(stopA), .data_write_en(dweA),
      .jump_load(jlA), .jump_target(jtA), .pc(pcA), .iram_rd_en(iramRdEnA),
      .opcode(opA), .imm(immA), .exec_en(execEnA), .data_we(dataWeA),
      .busy(busyA), .done(doneA)
   );

   instr_sequencer #(.PC_WIDTH(PCW), .IMM_WIDTH(IMMW), .IRAM_LATENCY(3), .DRAM_WAIT(DW)) dutB (
      .clk(clk), .rst(rst), .start(startB), .iram_data(iramDataB),
      .pc_en(pcEnB), .stop_flag(stopB), .data_write_en(dweB),
      .jump_load(jlB), .jump_target(jtB), .pc(pcB), .iram_rd_en(iramRdEnB),
      .opcode(opB), .imm(immB), .exec_en(execEnB), .data_we(dataWeB),
      .busy(busyB), .done(doneB)
   );

   // Toy decoders: STRSTOP raises both stop and write to exercise their priority.
   assign stopA = (opA == OP_STOP) || (opA == OP_STRSTOP);
   assign dweA  = (opA == OP_STR) || (opA == OP_STRSTOP);
   assign pcEnA = !stopA;
   assign jlA   = (opA == OP_JUMPX);
   assign jtA   = immA;
   assign stopB = (opB == OP_STOP) || (opB == OP_STRSTOP);
   assign dweB  = (opB == OP_STR) || (opB == OP_STRSTOP);
   assign pcEnB = !stopB;
   assign jlB   = (opB == OP_JUMPX);
   assign jtB   = immB;

   // Instruction RAMs return the word exactly IRAM_LATENCY cycles after the read, junk otherwise.
   logic       vA = 1'b0;
   logic [7:0] aA = '0;
   logic [2:0] vB = '0;
   logic [7:0] aB0 = '0, aB1 = '0, aB2 = '0;

   always @(posedge clk) begin
      vA  <= iramRdEnA;
      aA  <= pcA;
      vB  <= {vB[1:0], iramRdEnB};
      aB0 <= pcB;
      aB1 <= aB0;
      aB2 <= aB1;
   end

   assign iramDataA = vA ? memA[aA] : JUNK;
   assign iramDataB = vB[2] ? memB[aB2] : JUNK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops fetch/execute expectations and tracks data_we runs, sampled 1 after the edge.
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (iramRdEnA) begin
         if (fetchQ.size() == 0) begin
            checkOutput("fetch_extra", {24'h0, pcA}, 32'hFFFF_FFFF);
         end else begin
            expAddr = fetchQ.pop_front();
            checkOutput("fetch_addr", {24'h0, pcA}, {24'h0, expAddr});
         end
      end
      if (execEnA) begin
         if (execQ.size() == 0) begin
            checkOutput("exec_extra", {24'h0, pcA}, 32'hFFFF_FFFF);
         end else begin
            rec = execQ.pop_front();
            checkOutput("exec_pc", {24'h0, pcA}, {24'h0, rec.pc});
            checkOutput("exec_op", {26'h0, opA}, {26'h0, rec.op});
            checkOutput("exec_imm", {24'h0, immA}, {24'h0, rec.imm});
            if (rec.gap != 0) checkOutput("exec_gap", cyc - lastExecA, rec.gap);
            lastExecA = cyc;
            if (rec.op == OP_STR) strExecA = cyc;
         end
      end
      if (dataWeA) begin
         if (!weLastA) checkOutput("we_start", cyc, strExecA + 1);
         weRunA++;
      end else if (weLastA) begin
         checkOutput("we_len", weRunA, DW);
         weRunA = 0;
         weRuns++;
      end
      weLastA = dataWeA;
      if (iramRdEnB) fetchCntB++;
   end

   task automatic applyStimulus();
      @(negedge clk);
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
   endtask

   task automatic pushExec(input logic [7:0] p, input logic [5:0] o, input logic [7:0] i, input int g);
      execRec_t r;
      r.pc = p;
      r.op = o;
      r.imm = i;
      r.gap = g;
      execQ.push_back(r);
   endtask

   task automatic fillNoops();
      for (int i = 0; i < 256; i++) begin
         memA[i] = {OP_NOOP, 8'h00};
         memB[i] = {OP_NOOP, 8'h00};
      end
   endtask

   task automatic checkResetA(input string tag);
      checkOutput({tag, "_pc"}, {24'h0, pcA}, 32'h0);
      checkOutput({tag, "_opcode"}, {26'h0, opA}, {26'h0, OP_NOOP});
      checkOutput({tag, "_imm"}, {24'h0, immA}, 32'h0);
      checkOutput({tag, "_strobes"}, {29'h0, iramRdEnA, execEnA, dataWeA}, 32'h0);
      checkOutput({tag, "_busy_done"}, {30'h0, busyA, doneA}, 32'h0);
   endtask

   task automatic waitDoneA(input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (doneA) seen = 1'b1;
      end
      checkOutput("haltA_reached", {31'h0, seen}, 32'h1);
   endtask

   task automatic waitDoneB(input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (doneB) seen = 1'b1;
      end
      checkOutput("haltB_reached", {31'h0, seen}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      startA = 1'b0;
      startB = 1'b0;
      fillNoops();
      repeat (3) @(negedge clk);
      checkResetA("reset");
      rst = 1'b0;

      // NOOP stream: one instruction every three cycles, STOP at address 4.
      memA[4] = {OP_STOP, 8'h00};
      for (int i = 0; i < 5; i++) begin
         fetchQ.push_back(8'(i));
         pushExec(8'(i), (i == 4) ? OP_STOP : OP_NOOP, 8'h00, (i == 0) ? 0 : 3);
      end
      applyStimulus();
      checkOutput("busy_running", {31'h0, busyA}, 32'h1);
      waitDoneA(60);
      checkOutput("halt1_pc", {24'h0, pcA}, 32'h4);
      checkOutput("halt1_busy", {31'h0, busyA}, 32'h0);

      // LDP1 / STR / STOP: two write cycles after STR, then halt at pc 2.
      fillNoops();
      memA[0] = {OP_LDP1, 8'h12};
      memA[1] = {OP_STR, 8'h00};
      memA[2] = {OP_STOP, 8'h00};
      fetchQ.push_back(8'h00); fetchQ.push_back(8'h01); fetchQ.push_back(8'h02);
      pushExec(8'h00, OP_LDP1, 8'h12, 0);
      pushExec(8'h01, OP_STR, 8'h00, 3);
      pushExec(8'h02, OP_STOP, 8'h00, 5);
      applyStimulus();
      checkOutput("restart_done_drop", {31'h0, doneA}, 32'h0);
      waitDoneA(60);
      repeat (3) @(negedge clk);
      checkOutput("halt2_pc", {24'h0, pcA}, 32'h2);
      checkOutput("halt2_ir", {26'h0, opA}, {26'h0, OP_STOP});
      checkOutput("halt2_flags", {30'h0, busyA, doneA}, 32'h1);
      checkOutput("write_runs2", weRuns, 1);

      // JUMPX at pc 5 with pc_en also high: the jump target wins.
      fillNoops();
      memA[5] = {OP_JUMPX, 8'h40};
      memA[8'h40] = {OP_STOP, 8'h00};
      for (int i = 0; i < 6; i++) begin
         fetchQ.push_back(8'(i));
         pushExec(8'(i), (i == 5) ? OP_JUMPX : OP_NOOP, (i == 5) ? 8'h40 : 8'h00, (i == 0) ? 0 : 3);
      end
      fetchQ.push_back(8'h40);
      pushExec(8'h40, OP_STOP, 8'h00, 3);
      applyStimulus();
      waitDoneA(80);
      checkOutput("halt3_pc", {24'h0, pcA}, 32'h40);

      // Wrap from 0xFF to 0x00, then a stop-plus-write that must halt without writing.
      fillNoops();
      memA[0] = {OP_JUMPX, 8'hFF};
      fetchQ.push_back(8'h00); fetchQ.push_back(8'hFF); fetchQ.push_back(8'h00);
      pushExec(8'h00, OP_JUMPX, 8'hFF, 0);
      pushExec(8'hFF, OP_NOOP, 8'h00, 3);
      pushExec(8'h00, OP_STRSTOP, 8'h00, 3);
      applyStimulus();
      for (int i = 0; i < 40 && fetchQ.size() > 1; i++) @(negedge clk);
      memA[0] = {OP_STRSTOP, 8'h00};
      waitDoneA(60);
      checkOutput("halt4_pc", {24'h0, pcA}, 32'h0);
      checkOutput("write_runs4", weRuns, 1);

      // Reset in the second write cycle, then a fresh run from address 0.
      fillNoops();
      memA[0] = {OP_STR, 8'h00};
      fetchQ.push_back(8'h00);
      pushExec(8'h00, OP_STR, 8'h00, 0);
      applyStimulus();
      for (int i = 0; i < 40 && !dataWeA; i++) @(negedge clk);
      @(negedge clk);
      checkOutput("mem_second_cycle", {31'h0, dataWeA}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      checkResetA("mid_mem");
      rst = 1'b0;
      memA[0] = {OP_NOOP, 8'h00};
      memA[1] = {OP_STOP, 8'h00};
      fetchQ.push_back(8'h00); fetchQ.push_back(8'h01);
      pushExec(8'h00, OP_NOOP, 8'h00, 0);
      pushExec(8'h01, OP_STOP, 8'h00, 3);
      applyStimulus();
      @(negedge clk);
      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      waitDoneA(60);
      checkOutput("halt5_pc", {24'h0, pcA}, 32'h1);
      checkOutput("write_runs5", weRuns, 2);

      // Three-cycle IRAM build: fetch in cycle 1, capture at end of 4, execute in 5.
      memB[0] = {OP_LDP1, 8'h33};
      memB[1] = {OP_STOP, 8'h00};
      @(negedge clk);
      startB = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         startB = (i == 2);
         checkOutput($sformatf("lat3_rd_c%0d", i), {31'h0, iramRdEnB}, {31'h0, (i == 1)});
         checkOutput($sformatf("lat3_exec_c%0d", i), {31'h0, execEnB}, {31'h0, (i == 5)});
         checkOutput($sformatf("lat3_op_c%0d", i), {26'h0, opB}, {26'h0, (i == 5) ? OP_LDP1 : OP_NOOP});
         checkOutput($sformatf("lat3_busy_c%0d", i), {31'h0, busyB}, 32'h1);
      end
      checkOutput("lat3_imm", {24'h0, immB}, 32'h33);
      waitDoneB(60);
      checkOutput("lat3_halt_pc", {24'h0, pcB}, 32'h1);
      checkOutput("lat3_fetches", fetchCntB, 2);

      repeat (2) @(negedge clk);
      checkOutput("fetchq_empty", fetchQ.size(), 0);
      checkOutput("execq_empty", execQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
